// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle RISC-V core: byte-lane RAM, one output
// register and a programmable-latency response with a single-cycle ready strobe.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [11:0] MMIO_ADDR  = 12'hFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_MEM_CSN,
    input  logic        D_MEM_WEN,
    input  logic [3:0]  D_MEM_BE,
    input  logic [11:0] D_MEM_ADDR,
    input  logic [31:0] D_MEM_DOUT,
    output logic [31:0] D_MEM_DI,
    output logic        D_MEM_RDY,
    output logic [31:0] OUT_REG,
    output logic        ERR
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [31:0]           rbuf;
    logic                  req_rd;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  is_mmio;
    logic                  is_ram;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Decode is taken from the live request; it only matters on an accepting edge.
    always_comb begin
        accept  = !RST && !D_MEM_CSN && (state == IDLE || state == RESP);
        is_mmio = (D_MEM_ADDR == MMIO_ADDR);
        is_ram  = !is_mmio && ((D_MEM_ADDR >> DEPTH_LOG2) == 12'd0);
        idx     = D_MEM_ADDR[DEPTH_LOG2-1:0];
        rd_word = 32'h0;
        if (is_mmio) begin
            rd_word = OUT_REG;
        end else if (is_ram) begin
            rd_word = mem[idx];
        end
    end

    // NOTE: the RAM array is deliberately left out of reset so it maps onto a plain
    // memory macro; contents survive RST and start undefined.
    always_ff @(posedge CLK) begin
        if (accept && !D_MEM_WEN && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (D_MEM_BE[i]) begin
                    mem[idx][8*i +: 8] <= D_MEM_DOUT[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rbuf      <= 32'h0;
            req_rd    <= 1'b0;
            D_MEM_DI  <= 32'h0;
            D_MEM_RDY <= 1'b0;
            OUT_REG   <= 32'h0;
            ERR       <= 1'b0;
        end else begin
            D_MEM_RDY <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (!D_MEM_CSN) begin
                        req_rd <= D_MEM_WEN;
                        rbuf   <= rd_word;
                        if (!D_MEM_WEN && is_mmio) begin
                            OUT_REG <= merge_bytes(OUT_REG, D_MEM_DOUT, D_MEM_BE);
                        end
                        if (!is_mmio && !is_ram) begin
                            ERR <= 1'b1;
                        end
                        // Single-cycle latency enters RESP straight from the accepting edge.
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            D_MEM_RDY <= 1'b1;
                            if (D_MEM_WEN) begin
                                D_MEM_DI <= rd_word;
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        D_MEM_RDY <= 1'b1;
                        if (req_rd) begin
                            D_MEM_DI <= rbuf;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) checked against a
// transaction-level memory model, a directed vector table and reset corner cases.
module tb_dmem_responder;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp_di;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        csn     [3];
    logic        wen     [3];
    logic [3:0]  be      [3];
    logic [11:0] addr    [3];
    logic [31:0] dout    [3];
    logic [31:0] di      [3];
    logic        rdy     [3];
    logic [31:0] out_reg [3];
    logic        err     [3];

    int checks = 0;
    int errors = 0;

    // Reference model: word store keyed by instance and address.
    logic [31:0] mem_m [int];
    logic [31:0] out_m [3];
    logic        err_m [3];
    logic [31:0] di_m  [3];
    bit          di_kn [3];
    req_t        req_q [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2(10),
            .LATENCY   (g == 0 ? 1 : (g == 1 ? 3 : 4)),
            .MMIO_ADDR (12'hFFF)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .D_MEM_CSN (csn[g]),
            .D_MEM_WEN (wen[g]),
            .D_MEM_BE  (be[g]),
            .D_MEM_ADDR(addr[g]),
            .D_MEM_DOUT(dout[g]),
            .D_MEM_DI  (di[g]),
            .D_MEM_RDY (rdy[g]),
            .OUT_REG   (out_reg[g]),
            .ERR       (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be_i);
        logic [31:0] mask;
        mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            out_m[g] = 32'h0;
            err_m[g] = 1'b0;
            di_m[g]  = 32'h0;
            di_kn[g] = 1'b1;
        end
    endtask

    task automatic model_apply(input int g, input req_t r, output logic [31:0] exp_di, output bit kn);
        int key;
        key = g * 4096 + int'(r.addr);
        if (!r.wen) begin
            if (r.addr == 12'hFFF) begin
                out_m[g] = byte_merge(out_m[g], r.data, r.be);
            end else if (r.addr < 12'h400) begin
                if (mem_m.exists(key)) mem_m[key] = byte_merge(mem_m[key], r.data, r.be);
                else if (r.be == 4'hF) mem_m[key] = r.data;
            end else begin
                err_m[g] = 1'b1;
            end
        end else begin
            if (r.addr == 12'hFFF) begin
                di_m[g]  = out_m[g];
                di_kn[g] = 1'b1;
            end else if (r.addr < 12'h400) begin
                di_kn[g] = mem_m.exists(key);
                if (di_kn[g]) di_m[g] = mem_m[key];
            end else begin
                di_m[g]  = 32'h0;
                di_kn[g] = 1'b1;
                err_m[g] = 1'b1;
            end
        end
        exp_di = di_m[g];
        kn     = di_kn[g];
    endtask

    task automatic present(input int g, input req_t r);
        csn[g]  = 1'b0;
        wen[g]  = r.wen;
        be[g]   = r.be;
        addr[g] = r.addr;
        dout[g] = r.data;
    endtask

    task automatic idle(input int g);
        csn[g] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Issues req_q back to back; the next request is presented right after each
    // accepting edge and the core holds it until accepted.
    task automatic run_stream(input int g, output logic [31:0] last_di);
        int          lat;
        int          n;
        int          got;
        int          cyc;
        int          pidx;
        int          extra;
        bit          will_accept;
        logic [31:0] e;
        bit          k;
        logic [31:0] exp_q [$];
        bit          kn_q  [$];
        lat = lat_of(g);
        n   = req_q.size();
        for (int i = 0; i < n; i++) begin
            model_apply(g, req_q[i], e, k);
            exp_q.push_back(e);
            kn_q.push_back(k);
        end
        @(negedge clk);
        present(g, req_q[0]);
        pidx        = 0;
        got         = 0;
        cyc         = 0;
        will_accept = 1'b1;
        while (got < n && cyc < n * lat + 20) begin
            @(negedge clk);
            cyc++;
            if (will_accept && pidx < n) begin
                pidx++;
                if (pidx < n) present(g, req_q[pidx]);
                else idle(g);
            end
            if (rdy[g]) begin
                check($sformatf("g%0d_rdy_cycle_%0d", g, got), 32'(cyc), 32'((got + 1) * lat));
                if (kn_q[got]) check($sformatf("g%0d_di_%0d", g, got), di[g], exp_q[got]);
                got++;
            end
            will_accept = rdy[g];
        end
        idle(g);
        if (got < n) check($sformatf("g%0d_rdy_timeout", g), 32'(got), 32'(n));
        extra = 0;
        repeat (lat + 2) begin
            @(negedge clk);
            if (rdy[g]) extra++;
        end
        check($sformatf("g%0d_extra_rdy", g), 32'(extra), 32'h0);
        last_di = di[g];
        req_q.delete();
    endtask

    vec_t        vecs [17];
    logic [31:0] got_di;
    logic [31:0] e;
    bit          kn;
    req_t        r;
    int          nrdy;

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 12'h005, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b1, 4'h0, 12'h005, 32'h00000000, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'hF, 12'h000, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'hF, 12'h006, 32'h11223344, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 4'h5, 12'h006, 32'hAABBCCDD, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 4'h0, 12'h006, 32'h00000000, 32'h11BB33DD};
        vecs[6]  = '{1'b0, 4'h0, 12'h006, 32'h55555555, 32'h11BB33DD};
        vecs[7]  = '{1'b1, 4'hF, 12'h006, 32'h00000000, 32'h11BB33DD};
        vecs[8]  = '{1'b0, 4'hF, 12'hFFF, 32'h0000000C, 32'h11BB33DD};
        vecs[9]  = '{1'b1, 4'h0, 12'hFFF, 32'h00000000, 32'h0000000C};
        vecs[10] = '{1'b0, 4'hF, 12'h400, 32'h99999999, 32'h0000000C};
        vecs[11] = '{1'b1, 4'h0, 12'h400, 32'h00000000, 32'h00000000};
        vecs[12] = '{1'b1, 4'h0, 12'h000, 32'h00000000, 32'hA5A5A5A5};
        vecs[13] = '{1'b0, 4'hF, 12'h007, 32'h12345678, 32'hA5A5A5A5};
        vecs[14] = '{1'b0, 4'hF, 12'h008, 32'hCAFEF00D, 32'hA5A5A5A5};
        vecs[15] = '{1'b1, 4'h0, 12'h007, 32'h00000000, 32'h12345678};
        vecs[16] = '{1'b1, 4'h0, 12'h008, 32'h00000000, 32'hCAFEF00D};

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            csn[g]  = 1'b1;
            wen[g]  = 1'b1;
            be[g]   = 4'h0;
            addr[g] = 12'h0;
            dout[g] = 32'h0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int g = 0; g < 3; g++) begin
            check($sformatf("g%0d_reset_di", g), di[g], 32'h0);
            check($sformatf("g%0d_reset_rdy", g), 32'(rdy[g]), 32'h0);
            check($sformatf("g%0d_reset_out", g), out_reg[g], 32'h0);
            check($sformatf("g%0d_reset_err", g), 32'(err[g]), 32'h0);
        end

        // Directed vectors on the single-cycle instance.
        for (int i = 0; i < 17; i++) begin
            req_q.push_back('{vecs[i].wen, vecs[i].be, vecs[i].addr, vecs[i].data});
            run_stream(0, got_di);
            check($sformatf("vec%0d_di", i), got_di, vecs[i].exp_di);
        end
        check("vec_out_reg", out_reg[0], 32'h0000000C);
        check("vec_err_sticky", 32'(err[0]), 32'h1);

        // LATENCY=3: held read, then back-to-back reads.
        for (int i = 1; i <= 4; i++) req_q.push_back('{1'b0, 4'hF, 12'(i), 32'hB0000000 + 32'(i)});
        run_stream(1, got_di);
        r = '{1'b1, 4'h0, 12'h003, 32'h0};
        model_apply(1, r, e, kn);
        @(negedge clk);
        present(1, r);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("held_rdy_c%0d", c), 32'(rdy[1]), 32'(c == 3));
            if (c == 3) begin
                check("held_di", di[1], e);
                idle(1);
            end
        end
        for (int i = 4; i >= 1; i--) req_q.push_back('{1'b1, 4'h0, 12'(i), 32'h0});
        run_stream(1, got_di);

        // Randomized traffic against the model on the 1- and 3-cycle instances.
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 16; a++) req_q.push_back('{1'b0, 4'hF, 12'(a), $urandom});
            run_stream(g, got_di);
            for (int i = 0; i < 40; i++) begin
                int sel;
                sel = int'($urandom_range(0, 19));
                r.wen  = 1'($urandom);
                r.be   = 4'($urandom);
                r.data = $urandom;
                if (sel < 16) r.addr = 12'(sel);
                else if (sel == 16) r.addr = 12'hFFF;
                else if (sel == 17) r.addr = 12'h400;
                else if (sel == 18) r.addr = 12'h800 | 12'($urandom_range(0, 2047));
                else r.addr = 12'hFFE;
                req_q.push_back(r);
            end
            run_stream(g, got_di);
            check($sformatf("g%0d_rand_out", g), out_reg[g], out_m[g]);
            check($sformatf("g%0d_rand_err", g), 32'(err[g]), 32'(err_m[g]));
        end

        do_reset();
        check("err_cleared_by_rst", 32'(err[0]), 32'h0);
        check("out_cleared_by_rst", out_reg[0], 32'h0);

        // LATENCY=4: reset while a request is in flight.
        req_q.push_back('{1'b0, 4'hF, 12'h00A, 32'h0A0A0A0A});
        run_stream(2, got_di);
        for (int pass = 0; pass < 2; pass++) begin
            r = (pass == 0) ? '{1'b0, 4'hF, 12'h009, 32'h0BADF00D} : '{1'b1, 4'h0, 12'h009, 32'h0};
            model_apply(2, r, e, kn);
            nrdy = 0;
            @(negedge clk);
            present(2, r);
            @(negedge clk);
            if (rdy[2]) nrdy++;
            idle(2);
            @(negedge clk);
            if (rdy[2]) nrdy++;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            repeat (8) begin
                @(negedge clk);
                if (rdy[2]) nrdy++;
            end
            check($sformatf("rst_wait%0d_no_rdy", pass), 32'(nrdy), 32'h0);
            check($sformatf("rst_wait%0d_di", pass), di[2], 32'h0);
            if (pass == 0) begin
                req_q.push_back('{1'b1, 4'h0, 12'h009, 32'h0});
                run_stream(2, got_di);
                check("write_survives_rst", got_di, 32'h0BADF00D);
            end
        end

        // A request that coincides with RST is not accepted.
        nrdy = 0;
        @(negedge clk);
        rst = 1'b1;
        present(2, '{1'b0, 4'hF, 12'h00A, 32'h77777777});
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        model_reset();
        repeat (6) begin
            @(negedge clk);
            if (rdy[2]) nrdy++;
        end
        check("rst_req_no_rdy", 32'(nrdy), 32'h0);
        req_q.push_back('{1'b1, 4'h0, 12'h00A, 32'h0});
        run_stream(2, got_di);
        check("rst_req_not_written", got_di, 32'h0A0A0A0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
